// File: rtl/shift_arbiter.sv
// Two-requester shift unit: arbitrates, latches one operation, shifts it, holds the response until it is taken.
// Optional SHIFT_ARB_RR_EN: round-robin grant; otherwise requester 0 has fixed priority.
module shift_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req1_a,
   input  logic [4:0]       req0_b,
   input  logic [4:0]       req1_b,
   input  logic             req0_sel,
   input  logic             req1_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_out,
   output logic             rsp_of,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_r;
   logic [31:0]      a_r;
   logic [4:0]       b_r;
   logic             sel_r;
   logic             id_r;
   logic             rsp_valid_r;
   logic             rsp_id_r;
   logic             rsp_of_r;
   logic [31:0]      rsp_out_r;
   logic [CNT_W-1:0] op_count_r;

   logic             any_valid_s;
   logic             grant_id_s;
   logic             accept_s;
   logic [32:0]      shift_res_s;

   // Returns {overflow, result}; overflow only meaningful for left shifts.
   function automatic logic [32:0] shift_calc(input logic [31:0] a,
                                              input logic [4:0]  b,
                                              input logic        sel);
      logic signed [31:0] sa;
      logic [31:0]        res;
      logic               of;
      sa  = a;
      res = 32'h0000_0000;
      of  = 1'b0;
      if (b == 5'd0) begin
         res = a;
         of  = 1'b0;
      end else if (sel == 1'b0) begin
         res = a << b;
         of  = res[31] ^ a[31];
      end else begin
         res = sa >>> b;
         of  = 1'b0;
      end
      return {of, res};
   endfunction

`ifdef SHIFT_ARB_RR_EN
   logic ptr_r;

   // Grant selection: pointer breaks ties between simultaneous requests.
   always_comb begin
      grant_id_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id_s = ptr_r;
      end else if (req1_valid) begin
         grant_id_s = 1'b1;
      end else begin
         grant_id_s = 1'b0;
      end
   end

   // Pointer moves to the loser of each grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= 1'b0;
      end else if (accept_s) begin
         ptr_r <= ~grant_id_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   // Grant selection: requester 0 always wins a tie.
   always_comb begin
      grant_id_s = 1'b0;
      if (req0_valid) begin
         grant_id_s = 1'b0;
      end else if (req1_valid) begin
         grant_id_s = 1'b1;
      end else begin
         grant_id_s = 1'b0;
      end
   end
`endif

   // Acceptance and the combinational ready handshake.
   always_comb begin
      any_valid_s = req0_valid | req1_valid;
      accept_s    = (state_r == IDLE) && !rst && any_valid_s;
      req0_ready  = accept_s && (grant_id_s == 1'b0);
      req1_ready  = accept_s && (grant_id_s == 1'b1);
   end

   // Shift result of the latched operands.
   always_comb begin
      shift_res_s = shift_calc(a_r, b_r, sel_r);
   end

   // Operand capture: only on acceptance, so later valid changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= 32'h0000_0000;
         b_r   <= 5'd0;
         sel_r <= 1'b0;
         id_r  <= 1'b0;
      end else if (accept_s) begin
         a_r   <= grant_id_s ? req1_a   : req0_a;
         b_r   <= grant_id_s ? req1_b   : req0_b;
         sel_r <= grant_id_s ? req1_sel : req0_sel;
         id_r  <= grant_id_s;
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         sel_r <= sel_r;
         id_r  <= id_r;
      end
   end

   // Control FSM, response registers and completion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rsp_valid_r <= 1'b0;
         rsp_out_r   <= 32'h0000_0000;
         rsp_of_r    <= 1'b0;
         rsp_id_r    <= 1'b0;
         op_count_r  <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               rsp_out_r   <= shift_res_s[31:0];
               rsp_of_r    <= shift_res_s[32];
               rsp_id_r    <= id_r;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  op_count_r  <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_r     <= IDLE;
               end else begin
                  state_r     <= RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_out   = rsp_out_r;
   assign rsp_of    = rsp_of_r;
   assign op_count  = op_count_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table plus backpressure, contention, reset and counter-wrap sequences.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req1_a;
   logic [4:0]  req0_b, req1_b;
   logic        req0_sel, req1_sel;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_of;
   logic [31:0] rsp_out;
   logic [15:0] op_count;

   logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_rsp_of;
   logic [31:0] w_rsp_out;
   logic [1:0]  w_op_count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [4:0]  b;
      logic        sel;
      logic [31:0] exp_out;
      logic        exp_of;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   shift_arbiter #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_sel(req0_sel), .req1_sel(req1_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_of(rsp_of), .op_count(op_count)
   );

   // Narrow-counter copy sharing the same stimulus, used for the wrap check.
   shift_arbiter #(.CNT_W(2)) dut_w (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(w_req0_ready), .req1_ready(w_req1_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_sel(req0_sel), .req1_sel(req1_sel),
      .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
      .rsp_out(w_rsp_out), .rsp_of(w_rsp_of), .op_count(w_op_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_op(input logic id, input logic [31:0] a, input logic [4:0] b, input logic sel);
      req0_valid = (id == 1'b0);
      req1_valid = (id == 1'b1);
      req0_a = a; req1_a = a;
      req0_b = b; req1_b = b;
      req0_sel = sel; req1_sel = sel;
   endtask

   task automatic do_op(input vec_t v);
      @(negedge clk);
      drive_op(v.id, v.a, v.b, v.sel);
      rsp_ready = 1'b1;
      #1;
      chk("accept_ready0", {31'd0, req0_ready}, {31'd0, ~v.id});
      chk("accept_ready1", {31'd0, req1_ready}, {31'd0, v.id});
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("resp_out", rsp_out, v.exp_out);
      chk("resp_of", {31'd0, rsp_of}, {31'd0, v.exp_of});
      chk("resp_id", {31'd0, rsp_id}, {31'd0, v.id});
      exp_count++;
      @(negedge clk);
      chk("idle_valid_low", {31'd0, rsp_valid}, 32'd0);
      chk("op_count", {16'd0, op_count}, exp_count);
      chk("op_count_w", {30'd0, w_op_count}, exp_count % 4);
   endtask

   initial begin
      logic [3:0] exp_ids;
      int n;
`ifdef SHIFT_ARB_RR_EN
      exp_ids = 4'b1010;
`else
      exp_ids = 4'b0000;
`endif
      vecs[0] = '{1'b0, 32'h4000_0000, 5'd1,  1'b0, 32'h8000_0000, 1'b1};
      vecs[1] = '{1'b1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0};
      vecs[2] = '{1'b0, 32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b0};
      vecs[3] = '{1'b1, 32'h8765_4321, 5'd0,  1'b1, 32'h8765_4321, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b1};
      vecs[5] = '{1'b1, 32'hFFFF_FFFF, 5'd4,  1'b0, 32'hFFFF_FFF0, 1'b0};
      vecs[6] = '{1'b0, 32'h7FFF_FFFF, 5'd4,  1'b1, 32'h07FF_FFFF, 1'b0};
      vecs[7] = '{1'b1, 32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000, 1'b0};
      vecs[8] = '{1'b0, 32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002, 1'b1};
      vecs[9] = '{1'b1, 32'h0000_0003, 5'd30, 1'b0, 32'hC000_0000, 1'b1};

      // Reset with both requesters asking: readys must stay low.
      rst = 1'b1; rsp_ready = 1'b1;
      drive_op(1'b0, 32'h0000_0001, 5'd1, 1'b0);
      req1_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_out", rsp_out, 32'd0);
      chk("rst_of_id", {30'd0, rsp_of, rsp_id}, 32'd0);
      chk("rst_count", {16'd0, op_count}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;

      for (int i = 0; i < 10; i++) do_op(vecs[i]);

      // Backpressure: response held for 5 cycles, new operands ignored.
      @(negedge clk);
      drive_op(1'b0, 32'h0000_0010, 5'd2, 1'b1);
      rsp_ready = 1'b0;
      @(negedge clk);
      req1_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_out", rsp_out, 32'h0000_0004);
         chk("bp_id", {31'd0, rsp_id}, 32'd0);
         chk("bp_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      exp_count++;
      @(negedge clk);
      chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_release_idle", {31'd0, req0_ready}, 32'd1);
      chk("bp_count", {16'd0, op_count}, exp_count);
      req0_valid = 1'b0;

      // Contention after a fresh reset so the pointer starts at requester 0.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; exp_count = 0;
      drive_op(1'b0, 32'h0000_0003, 5'd1, 1'b0);
      req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!rsp_valid && n < 10);
         chk("cont_seen", {31'd0, rsp_valid}, 32'd1);
         chk("cont_id", {31'd0, rsp_id}, {31'd0, exp_ids[k]});
         chk("cont_out", rsp_out, 32'h0000_0006);
         exp_count++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("cont_count", {16'd0, op_count}, exp_count);

      // Reset one cycle after accept: operation abandoned.
      @(negedge clk);
      drive_op(1'b1, 32'h0000_0001, 5'd3, 1'b0);
      @(negedge clk);
      req1_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; exp_count = 0;
      for (int i = 0; i < 3; i++) begin
         chk("abandon_valid", {31'd0, rsp_valid}, 32'd0);
         chk("abandon_count", {16'd0, op_count}, 32'd0);
         @(negedge clk);
      end

      // Five more operations: narrow counter wraps to 1.
      for (int i = 0; i < 5; i++) do_op(vecs[i]);
      chk("wrap_count_w", {30'd0, w_op_count}, 32'd1);
      chk("wrap_count", {16'd0, op_count}, 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a / req1_a  input  32  signed operand.
REQ-007 SHALL have ports req0_b / req1_b  input  5  shift amount, 0-31.
REQ-008 SHALL have ports req0_sel / req1_sel  input  1  0 = left shift, 1 = arithmetic right shift.
REQ-009 SHALL have port rsp_valid  output  1  result is available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-011 SHALL have port rsp_id  output  1  requester index of the result.
REQ-012 SHALL have port rsp_out  output  32  signed shift result.
REQ-013 SHALL have port rsp_of  output  1  overflow flag.
REQ-014 SHALL have port op_count  output  CNT_W  count of completed responses.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, EXEC and RESP.
REQ-016 In IDLE with any reqN_valid high, SHALL grant one requester, assert only that reqN_ready combinationally in the same cycle, latch a/b/sel/id, and go to EXEC.
REQ-017 SHALL hold every reqN_ready low outside IDLE, and in IDLE for any requester not granted.
REQ-018 In EXEC, SHALL compute the shift on the latched operands, register rsp_out/rsp_of/rsp_id, and go to RESP.
REQ-019 In RESP, SHALL assert rsp_valid and hold rsp_out/rsp_of/rsp_id stable until rsp_ready is high, then go to IDLE with rsp_valid low in the next cycle.
REQ-020 Latency: accept on cycle T gives rsp_valid on cycle T+2; back-to-back operations with rsp_ready held high are accepted no more often than every 3 cycles.
REQ-021 For sel=0, SHALL set rsp_out = a << b with zero fill (bits shifted out are discarded) and rsp_of = rsp_out[31] XOR a[31].
REQ-022 For sel=1, SHALL set rsp_out = a >>> b with sign fill and rsp_of = 0.
REQ-023 For b=0, SHALL set rsp_out = a and rsp_of = 0.
REQ-024 SHALL increment op_count by 1 on each RESP-to-IDLE transition, wrapping from 2^CNT_W-1 to 0.
REQ-025 SHALL not let reqN_valid changes during EXEC or RESP alter the latched operation.

Reset
REQ-026 With rst high at a clock edge, SHALL enter IDLE and clear rsp_valid, rsp_out, rsp_of, rsp_id, op_count and the priority pointer to 0.
REQ-027 Reset during EXEC or RESP SHALL abandon the operation: no response is issued and op_count is not incremented.
REQ-028 While rst is high, SHALL hold req0_ready and req1_ready low.

Configuration
REQ-029 With SHIFT_ARB_RR_EN defined, grant SHALL be round-robin: the priority pointer moves to the requester not granted on each grant, and requester 0 has priority after reset.
REQ-030 With SHIFT_ARB_RR_EN undefined, grant SHALL be fixed priority: requester 0 wins whenever both are valid, and no pointer state exists.

Verification
REQ-031 Single left shift: req0 a=0x40000000, b=1, sel=0, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_out=0x80000000, rsp_of=1, rsp_id=0, op_count=1.
REQ-032 Arithmetic right shift: req1 a=0x80000000, b=31, sel=1 -> rsp_out=0xFFFFFFFF, rsp_of=0, rsp_id=1.
REQ-033 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, both readys low; rsp_ready=1 -> IDLE next cycle.
REQ-034 Contention: both requesters valid continuously, 4 operations -> with SHIFT_ARB_RR_EN rsp_id sequence is 0,1,0,1; without it, 0,0,0,0.
REQ-035 Reset mid-EXEC: rst pulsed the cycle after accept -> no rsp_valid, op_count=0, next request accepted normally.
REQ-036 Wrap: CNT_W=2, 5 operations -> op_count reads 1.
